crc_engine_mc: RTL and testbench

Parametrised, multi-channel successor to the single-context MKW2xD CRC peripheral. It holds NUM_CH independent CRC contexts (DATA/GPOLY/CTRL register triplets) behind one memory-mapped slave port, and shares one sequential shift engine between them. The engine processes BPC bits per clock, so a write finishes in a bounded number of cycles instead of one combinational loop. It adds 8/16/32-bit CRC widths, byte/halfword/word write sizes, a bus stall handshake and a busy flag.

---
 rtl/crc_pkg.sv | 61 ++++++
 rtl/crc_step.sv | 37 +++
 rtl/crc_engine_mc.sv | 138 +++++++++++++
 tb/tb_crc_engine_mc.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the multi-channel CRC engine: register map, CTRL
// field positions, reset values, FSM/transpose enums and field helpers.
package crc_pkg;

  localparam logic [1:0] OFF_DATA  = 2'd0;
  localparam logic [1:0] OFF_GPOLY = 2'd1;
  localparam logic [1:0] OFF_CTRL  = 2'd2;

  localparam int unsigned CTRL_TOT  = 30;
  localparam int unsigned CTRL_TOTR = 28;
  localparam int unsigned CTRL_FXOR = 26;
  localparam int unsigned CTRL_WAS  = 25;
  localparam int unsigned CTRL_TCRC = 24;
  localparam int unsigned CTRL_W8   = 23;

  localparam logic [31:0] SEED_RST = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY_RST = 32'h0000_1021;

  typedef enum logic {IDLE, SHIFT} state_e;
  typedef enum logic [1:0] {TP_NONE, TP_BITS, TP_FULL, TP_BYTES} tmode_e;

  function automatic logic [31:0] field_mask(input logic [2:0] nbytes);
    case (nbytes)
      3'd1:    return 32'h0000_00FF;
      3'd2:    return 32'h0000_FFFF;
      default: return '1;
    endcase
  endfunction

  function automatic logic [2:0] width_bytes(input logic tcrc, input logic w8);
    if (tcrc)    return 3'd4;
    else if (w8) return 3'd1;
    else         return 3'd2;
  endfunction

  // Operates on the low nbytes*8 bits only; everything above is returned as 0.
  function automatic logic [31:0] transpose(input logic [31:0] value, input tmode_e mode,
                                            input logic [2:0] nbytes);
    logic [31:0] v;
    logic [31:0] r;
    int unsigned nb;
    v  = value & field_mask(nbytes);
    r  = '0;
    nb = 32'(nbytes) * 8;
    case (mode)
      TP_NONE: r = v;
      TP_BITS:
        for (int unsigned i = 0; i < 32; i++)
          r[5'(i)] = v[5'((i & ~32'd7) | (32'd7 - (i & 32'd7)))];
      TP_FULL:
        for (int unsigned i = 0; i < 32; i++)
          if (i < nb) r[5'(i)] = v[5'(nb - 1 - i)];
      TP_BYTES:
        for (int unsigned b = 0; b < 4; b++)
          if (b * 8 < nb) r[5'(b * 8) +: 8] = v[5'(nb - 8 - b * 8) +: 8];
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/crc_step.sv
// One engine clock of CRC work: consumes up to BPC data bits, MSB first,
// using direct (non-augmented) feedback on a 8/16/32-bit register.
module crc_step
  import crc_pkg::*;
#(
  parameter int unsigned BPC = 8
) (
  input  logic [31:0]    i_crc,
  input  logic [31:0]    i_poly,
  input  logic [2:0]     i_nbytes,
  input  logic [BPC-1:0] i_data,
  input  logic [5:0]     i_nvalid,
  output logic [31:0]    o_crc
);

  logic [31:0]    w_c;
  logic [31:0]    w_m;
  logic [BPC-1:0] w_d;
  logic           w_fb;

  always_comb begin
    w_m  = field_mask(i_nbytes);
    w_c  = i_crc & w_m;
    w_d  = i_data;
    w_fb = 1'b0;
    for (int unsigned i = 0; i < BPC; i++) begin
      if (i < 32'(i_nvalid)) begin
        w_fb = w_d[BPC-1] ^ ((i_nbytes == 3'd1) ? w_c[7] :
                             (i_nbytes == 3'd2) ? w_c[15] : w_c[31]);
        w_c  = ((w_c << 1) ^ (w_fb ? i_poly : 32'h0)) & w_m;
      end
      w_d = w_d << 1;
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/crc_engine_mc.sv
// Multi-channel CRC peripheral: NUM_CH register contexts on one slave port,
// sharing a sequential engine that processes BPC bits per clock.
module crc_engine_mc
  import crc_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned BPC       = 8,
  parameter logic [31:0] BASE_ADDR = 32'h4003_2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Sel,
  input  logic        RW,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
  output logic        ready,
  output logic        busy
);

  localparam int unsigned CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [5:0]  BPC6 = 6'(BPC);

  logic [31:0]    r_crc  [NUM_CH];
  logic [31:0]    r_poly [NUM_CH];
  logic [31:0]    r_ctrl [NUM_CH];
  state_e         r_state, w_next;
  logic [31:0]    r_shreg;
  logic [5:0]     r_left;
  logic [CHW-1:0] r_act;
  logic [31:0]    r_rd;

  logic [31:0]    w_off, w_ctl, w_wfield, w_walign, w_seed, w_r, w_rdata, w_step;
  logic [CHW-1:0] w_ch;
  logic [1:0]     w_reg;
  logic [2:0]     w_wnb, w_cnb, w_anb;
  logic [5:0]     w_nbits, w_nvalid;
  logic           w_map, w_busy, w_stall, w_acc;

  // Subtraction wraps for addresses below the base, so one compare covers both sides.
  assign w_off = addr - BASE_ADDR;
  assign w_reg = w_off[3:2];
  assign w_ch  = w_off[4 +: CHW];
  assign w_map = (w_off < 32'(16 * NUM_CH)) && (w_reg != 2'd3);
  assign w_ctl = r_ctrl[w_ch];

  assign w_busy  = (r_state == SHIFT);
  assign w_stall = w_busy && Sel && w_map &&
                   ((w_reg == OFF_DATA) ||
                    (RW && (w_ch == r_act) && ((w_reg == OFF_GPOLY) || (w_reg == OFF_CTRL))));
  assign ready   = !w_stall;
  assign busy    = w_busy;
  assign w_acc   = Sel && ready;
  assign data_rd = r_rd;

  assign w_wnb    = (size == 2'd0) ? 3'd1 : (size == 2'd1) ? 3'd2 : 3'd4;
  assign w_nbits  = {w_wnb, 3'b000};
  assign w_cnb    = width_bytes(w_ctl[CTRL_TCRC], w_ctl[CTRL_W8]);
  assign w_wfield = transpose(data_wr, tmode_e'(w_ctl[CTRL_TOT +: 2]), w_wnb);
  assign w_walign = w_wfield << (6'd32 - w_nbits);
  assign w_seed   = w_wfield & field_mask(w_cnb);

  always_comb begin
    w_r = r_crc[w_ch] & field_mask(w_cnb);
    if (w_ctl[CTRL_FXOR]) w_r = ~w_r & field_mask(w_cnb);
    w_rdata = '0;
    if (w_map) begin
      case (w_reg)
        OFF_DATA:  w_rdata = transpose(w_r, tmode_e'(w_ctl[CTRL_TOTR +: 2]), w_cnb);
        OFF_GPOLY: w_rdata = r_poly[w_ch];
        OFF_CTRL:  w_rdata = w_ctl;
        default:   w_rdata = '0;
      endcase
    end
  end

  assign w_anb    = width_bytes(r_ctrl[r_act][CTRL_TCRC], r_ctrl[r_act][CTRL_W8]);
  assign w_nvalid = (r_left > BPC6) ? BPC6 : r_left;

  crc_step #(.BPC(BPC)) u_step (
    .i_crc    (r_crc[r_act]),
    .i_poly   (r_poly[r_act]),
    .i_nbytes (w_anb),
    .i_data   (r_shreg[31 -: BPC]),
    .i_nvalid (w_nvalid),
    .o_crc    (w_step)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc && RW && w_map && (w_reg == OFF_DATA) && !w_ctl[CTRL_WAS]) w_next = SHIFT;
      SHIFT:   if (r_left <= BPC6) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_crc   <= '{default: SEED_RST};
      r_poly  <= '{default: POLY_RST};
      r_ctrl  <= '{default: 32'h0};
      r_rd    <= '0;
      r_shreg <= '0;
      r_left  <= '0;
      r_act   <= '0;
    end else begin
      if (w_acc && !RW) r_rd <= w_rdata;
      if (w_busy) begin
        r_crc[r_act] <= w_step;
        r_shreg      <= r_shreg << BPC;
        r_left       <= r_left - w_nvalid;
      end
      // DATA writes only get here while idle, so they never collide with the engine update.
      if (w_acc && RW && w_map) begin
        case (w_reg)
          OFF_DATA:
            if (w_ctl[CTRL_WAS]) r_crc[w_ch] <= w_seed;
            else begin
              r_shreg <= w_walign;
              r_left  <= w_nbits;
              r_act   <= w_ch;
            end
          OFF_GPOLY: r_poly[w_ch] <= data_wr;
          OFF_CTRL:  r_ctrl[w_ch] <= data_wr;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crc_engine_mc.sv
// Bench for crc_engine_mc: directed CRC vectors, stall/reset/unmapped cases
// and randomized accesses checked against a bit-serial reference model.
module tb_crc_engine_mc;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned BPC    = 8;
  localparam logic [31:0] BASE   = 32'h4003_2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Sel;
  logic        RW;
  logic [31:0] addr;
  logic [1:0]  size;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        ready;
  logic        busy;

  crc_engine_mc #(.NUM_CH(NUM_CH), .BPC(BPC), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .Sel(Sel), .RW(RW), .addr(addr), .size(size),
    .data_wr(data_wr), .data_rd(data_rd), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int last_stalls;
  int m_busy_exp;

  logic [31:0] m_crc  [NUM_CH];
  logic [31:0] m_poly [NUM_CH];
  logic [31:0] m_ctrl [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int m_width(input logic [31:0] ctrl);
    if (ctrl[24]) return 32;
    return ctrl[23] ? 8 : 16;
  endfunction

  function automatic logic [31:0] m_mask(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] m_rev(input logic [31:0] v, input int n);
    logic [31:0] r = 0;
    for (int i = 0; i < n; i++) r = (r << 1) | ((v >> i) & 32'd1);
    return r;
  endfunction

  function automatic logic [31:0] m_trans(input logic [31:0] v0, input int mode, input int n);
    logic [31:0] v = v0 & m_mask(n);
    logic [31:0] r = 0;
    int nbyte = n / 8;
    case (mode)
      0: r = v;
      1: for (int k = 0; k < nbyte; k++) r |= m_rev((v >> (8 * k)) & 32'hFF, 8) << (8 * k);
      2: r = m_rev(v, n);
      default: for (int k = 0; k < nbyte; k++) r |= ((v >> (8 * k)) & 32'hFF) << (8 * (nbyte - 1 - k));
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ca(input int ch, input int rg);
    return BASE + 32'(16 * ch + 4 * rg);
  endfunction

  // Decodes an address; ch = -1 when unmapped.
  function automatic void m_decode(input logic [31:0] a, output int ch, output int rg);
    longint off = longint'(a) - longint'(BASE);
    ch = -1; rg = 0;
    if (off >= 0 && off < 16 * NUM_CH && ((off % 16) / 4) != 3) begin
      ch = int'(off / 16);
      rg = int'((off % 16) / 4);
    end
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_crc[c] = 32'hFFFF_FFFF; m_poly[c] = 32'h0000_1021; m_ctrl[c] = 32'h0;
    end
  endtask

  task automatic m_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int ch, rg, n, w;
    logic [31:0] f, c;
    logic fb;
    m_busy_exp = 0;
    m_decode(a, ch, rg);
    if (ch < 0) return;
    if (rg == 1) m_poly[ch] = d;
    else if (rg == 2) m_ctrl[ch] = d;
    else begin
      n = (sz == 0) ? 8 : (sz == 1) ? 16 : 32;
      w = m_width(m_ctrl[ch]);
      f = m_trans(d, int'(m_ctrl[ch][31:30]), n);
      if (m_ctrl[ch][25]) m_crc[ch] = f & m_mask(w);
      else begin
        c = m_crc[ch] & m_mask(w);
        for (int i = n - 1; i >= 0; i--) begin
          fb = c[w-1] ^ f[i];
          c  = ((c << 1) ^ (fb ? m_poly[ch] : 32'h0)) & m_mask(w);
        end
        m_crc[ch]  = c;
        m_busy_exp = (n + BPC - 1) / BPC;
      end
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int ch, rg, w;
    logic [31:0] r;
    m_decode(a, ch, rg);
    if (ch < 0) return 32'h0;
    if (rg == 1) return m_poly[ch];
    if (rg == 2) return m_ctrl[ch];
    w = m_width(m_ctrl[ch]);
    r = m_crc[ch] & m_mask(w);
    if (m_ctrl[ch][26]) r = ~r & m_mask(w);
    return m_trans(r, int'(m_ctrl[ch][29:28]), w);
  endfunction

  // ---------------- bus tasks (entered and left at a falling edge) ----------------
  task automatic xfer(input logic rw, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int stalls);
    Sel = 1'b1; RW = rw; addr = a; size = sz; data_wr = wd;
    stalls = 0;
    #1;
    while (!ready && stalls < 64) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (!ready) begin
      chk("ready_wait", 32'(ready), 32'h1);
      Sel = 1'b0; rd = '0;
      @(negedge clk);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    Sel = 1'b0; RW = 1'b0;
    rd = data_rd;
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] unused_rd;
    m_write(a, sz, d);
    xfer(1'b1, a, sz, d, unused_rd, last_stalls);
  endtask

  task automatic rdc(input string tag, input logic [31:0] a, output logic [31:0] got);
    xfer(1'b0, a, 2'd2, 32'h0, got, last_stalls);
    chk(tag, got, m_read(a));
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic feed_digits(input int ch, input bit check_busy);
    string s = "123456789";
    int nb;
    for (int i = 0; i < 9; i++) begin
      wr(ca(ch, 0), 2'd0, {24'h0, s[i]});
      count_busy(nb);
      if (check_busy) chk($sformatf("busy_byte%0d", i), 32'(nb), 32'h1);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, d, a;
    int nb, ch, rg;
    logic [1:0] sz;

    rst_n = 1'b0; Sel = 1'b0; RW = 1'b0; addr = '0; size = '0; data_wr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_data_rd", data_rd, 32'h0);
    rdc("rst_ctrl0", ca(0, 2), got);
    rdc("rst_poly0", ca(0, 1), got);
    rdc("rst_data0", ca(0, 0), got);
    chk("rst_data0_const", got, 32'h0000_FFFF);

    // CRC-16/CCITT-FALSE on channel 0
    wr(ca(0, 1), 2'd2, 32'h0000_1021);
    wr(ca(0, 2), 2'd2, 32'h0200_0000);
    wr(ca(0, 0), 2'd1, 32'h0000_FFFF);
    wr(ca(0, 2), 2'd2, 32'h0000_0000);
    feed_digits(0, 1'b1);
    rdc("crc16", ca(0, 0), got);
    chk("crc16_const", got, 32'h0000_29B1);

    // CRC-32 on channel 2: seed, then TOT=01, TOTR=10, FXOR, TCRC
    wr(ca(2, 1), 2'd2, 32'h04C1_1DB7);
    wr(ca(2, 2), 2'd2, 32'h0300_0000);
    wr(ca(2, 0), 2'd2, 32'hFFFF_FFFF);
    wr(ca(2, 2), 2'd2, 32'h6500_0000);
    feed_digits(2, 1'b0);
    rdc("crc32", ca(2, 0), got);
    chk("crc32_const", got, 32'hCBF4_3926);
    rdc("crc16_isolated", ca(0, 0), got);
    chk("crc16_isolated_const", got, 32'h0000_29B1);

    // CRC-8 on channel 1
    wr(ca(1, 2), 2'd2, 32'h0280_0000);
    wr(ca(1, 1), 2'd2, 32'h0000_0007);
    wr(ca(1, 0), 2'd0, 32'h0000_0000);
    wr(ca(1, 2), 2'd2, 32'h0080_0000);
    feed_digits(1, 1'b0);
    rdc("crc8", ca(1, 0), got);
    chk("crc8_const", got, 32'h0000_00F4);

    // Stall behaviour around a word write on channel 3
    wr(ca(3, 0), 2'd2, 32'h3132_3334);
    rdc("stall_data_val", ca(3, 0), got);
    chk("stall_data_cycles", 32'(last_stalls), 32'd4);
    wr(ca(3, 0), 2'd2, 32'hA5C3_0F96);
    rdc("other_poly_val", ca(1, 1), got);
    chk("other_poly_cycles", 32'(last_stalls), 32'd0);
    rdc("stall_data2_val", ca(3, 0), got);
    chk("stall_data2_cycles", 32'(last_stalls), 32'd3);
    wr(ca(3, 0), 2'd0, 32'h0000_005A);
    wr(ca(3, 1), 2'd2, 32'h0000_8005);
    chk("active_poly_wr_cycles", 32'(last_stalls), 32'd1);
    wr(ca(3, 0), 2'd2, 32'h1234_5678);
    wr(ca(1, 2), 2'd2, 32'h0080_0000);
    chk("other_ctrl_wr_cycles", 32'(last_stalls), 32'd0);
    count_busy(nb);
    rdc("active_poly_rd", ca(3, 1), got);
    rdc("after_poly_data", ca(3, 0), got);

    // Reset during the second busy cycle
    rdc("pre_rst_poly2", ca(2, 1), got);
    wr(ca(0, 0), 2'd2, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("busy_before_rst", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_ready", 32'(ready), 32'h1);
    chk("midrst_data_rd", data_rd, 32'h0);
    for (int c = 0; c < NUM_CH; c++) begin
      rdc($sformatf("midrst_data%0d", c), ca(c, 0), got);
      chk($sformatf("midrst_data%0d_const", c), got, 32'h0000_FFFF);
      rdc($sformatf("midrst_ctrl%0d", c), ca(c, 2), got);
    end

    // Unmapped accesses
    wr(ca(0, 1), 2'd2, 32'h0000_8BB7);
    rdc("pre_unmapped_poly", ca(0, 1), got);
    wr(ca(NUM_CH, 0), 2'd2, 32'h1111_2222);
    chk("unmapped_wr_ready", 32'(last_stalls), 32'd0);
    wr(ca(0, 3), 2'd2, 32'h3333_4444);
    chk("reserved_wr_ready", 32'(last_stalls), 32'd0);
    rdc("unmapped_rd", ca(NUM_CH, 0), got);
    chk("unmapped_rd_ready", 32'(last_stalls), 32'd0);
    rdc("reserved_rd", ca(0, 3), got);
    rdc("below_base_rd", BASE - 32'd4, got);
    wr(ca(0, 0), 2'd2, 32'h0BAD_F00D);
    rdc("busy_unmapped_rd", ca(NUM_CH, 1), got);
    chk("busy_unmapped_cycles", 32'(last_stalls), 32'd0);
    for (int c = 0; c < NUM_CH; c++) begin
      rdc($sformatf("post_unmapped_data%0d", c), ca(c, 0), got);
      rdc($sformatf("post_unmapped_poly%0d", c), ca(c, 1), got);
    end

    // Randomized register traffic
    for (int k = 0; k < 300; k++) begin
      ch = $urandom_range(NUM_CH, 0);
      rg = $urandom_range(3, 0);
      a  = ca(ch, rg);
      if ($urandom_range(1, 0) == 1) begin
        d  = $urandom;
        sz = 2'($urandom_range(3, 0));
        wr(a, sz, d);
        if (m_busy_exp > 0 && $urandom_range(1, 0) == 1) begin
          count_busy(nb);
          chk($sformatf("rnd_busy%0d", k), 32'(nb), 32'(m_busy_exp));
        end
      end else begin
        rdc($sformatf("rnd_rd%0d", k), a, got);
      end
    end
    count_busy(nb);
    for (int c = 0; c < NUM_CH; c++) rdc($sformatf("final_data%0d", c), ca(c, 0), got);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
